// File: rtl/battle_turn_ctrl.sv
// Turn controller: arbitrates two players' attack requests, samples the oscillator
// nibble per turn, applies damage to the defender and tracks the end of the game.
module battle_turn_ctrl #(
    parameter logic [3:0] HP_INIT       = 4'd9,
    parameter logic [3:0] HIT_THRESHOLD = 4'd7,
    parameter int         SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [3:0] rnd,
    output logic       rng_run,
    output logic [1:0] ack,
    output logic       busy,
    output logic [3:0] hp0,
    output logic [3:0] hp1,
    output logic       last_hit,
    output logic       last_attacker,
    output logic       game_over,
    output logic       winner
);

    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        RESOLVE = 3'd2,
        REPORT  = 3'd3,
        OVER    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_ptr;
    logic            r_attacker;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_hp0;
    logic [3:0]      r_hp1;
    logic            r_last_hit;
    logic            r_last_attacker;
    logic            r_game_over;
    logic            r_winner;
    logic [1:0]      r_ack;
    logic            r_busy;
    logic            r_rng_run;

    logic            w_grant_id;
    logic            w_hit;
    logic [3:0]      w_def_hp;
    logic [3:0]      w_def_hp_new;

    function automatic logic [1:0] f_damage(input logic [3:0] sample);
        if (sample == 4'hF)
            return 2'd2;
        else if (sample > HIT_THRESHOLD)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [3:0] f_sat_sub(input logic [3:0] hp, input logic [1:0] dmg);
        if (hp > {2'b00, dmg})
            return hp - {2'b00, dmg};
        else
            return 4'd0;
    endfunction

    // Arbitration and damage arithmetic
    always_comb begin
        w_grant_id   = r_ptr;
        w_hit        = (rnd > HIT_THRESHOLD);
        w_def_hp     = r_attacker ? r_hp0 : r_hp1;
        w_def_hp_new = f_sat_sub(w_def_hp, f_damage(rnd));
        if (req == 2'b01)
            w_grant_id = 1'b0;
        else if (req == 2'b10)
            w_grant_id = 1'b1;
        else
            w_grant_id = r_ptr;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req != 2'b00)
                    w_next_state = SETTLE;
                else
                    w_next_state = IDLE;
            end
            SETTLE: begin
                if (r_cnt == SETTLE_LAST)
                    w_next_state = RESOLVE;
                else
                    w_next_state = SETTLE;
            end
            RESOLVE: w_next_state = REPORT;
            REPORT: begin
                if (r_game_over)
                    w_next_state = OVER;
                else
                    w_next_state = IDLE;
            end
            OVER:    w_next_state = OVER;
            default: w_next_state = IDLE;
        endcase
    end

    // State, turn bookkeeping and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_ptr           <= 1'b0;
            r_attacker      <= 1'b0;
            r_cnt           <= '0;
            r_hp0           <= HP_INIT;
            r_hp1           <= HP_INIT;
            r_last_hit      <= 1'b0;
            r_last_attacker <= 1'b0;
            r_game_over     <= 1'b0;
            r_winner        <= 1'b0;
            r_ack           <= 2'b00;
            r_busy          <= 1'b0;
            r_rng_run       <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= (w_next_state == SETTLE) || (w_next_state == RESOLVE) ||
                         (w_next_state == REPORT);
            // Oscillator is held still only while its nibble is being captured
            r_rng_run <= (w_next_state != RESOLVE);
            if (w_next_state == REPORT)
                r_ack <= r_attacker ? 2'b10 : 2'b01;
            else
                r_ack <= 2'b00;

            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        r_attacker <= w_grant_id;
                        r_ptr      <= ~w_grant_id;
                        r_cnt      <= '0;
                    end
                end
                SETTLE: r_cnt <= r_cnt + CW'(1);
                RESOLVE: begin
                    // rnd is consumed directly so results are already visible in REPORT
                    if (r_attacker)
                        r_hp0 <= w_def_hp_new;
                    else
                        r_hp1 <= w_def_hp_new;
                    r_last_hit      <= w_hit;
                    r_last_attacker <= r_attacker;
                    if (w_def_hp_new == 4'd0) begin
                        r_game_over <= 1'b1;
                        r_winner    <= r_attacker;
                    end
                end
                REPORT:  r_cnt <= '0;
                OVER:    r_cnt <= '0;
                default: r_cnt <= '0;
            endcase
        end
    end

    assign rng_run       = r_rng_run;
    assign ack           = r_ack;
    assign busy          = r_busy;
    assign hp0           = r_hp0;
    assign hp1           = r_hp1;
    assign last_hit      = r_last_hit;
    assign last_attacker = r_last_attacker;
    assign game_over     = r_game_over;
    assign winner        = r_winner;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Self-checking bench for battle_turn_ctrl: directed turns plus random traffic,
// compared every cycle against a turn-timeline reference model.
module tb_battle_turn_ctrl;

    localparam int S = 3;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] rnd;
    logic       rng_run;
    logic [1:0] ack;
    logic       busy;
    logic [3:0] hp0;
    logic [3:0] hp1;
    logic       last_hit;
    logic       last_attacker;
    logic       game_over;
    logic       winner;

    int checks   = 0;
    int failures = 0;

    // Reference model: t = cycle index within the current turn (0 = no turn running)
    int       t;
    int       m_hp[2];
    bit       m_ptr, m_att, m_lh, m_la, m_go, m_win;

    battle_turn_ctrl #(.HP_INIT(4'd9), .HIT_THRESHOLD(4'd7), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .req(req), .rnd(rnd), .rng_run(rng_run), .ack(ack),
        .busy(busy), .hp0(hp0), .hp1(hp1), .last_hit(last_hit),
        .last_attacker(last_attacker), .game_over(game_over), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        t = 0; m_hp[0] = 9; m_hp[1] = 9;
        m_ptr = 0; m_att = 0; m_lh = 0; m_la = 0; m_go = 0; m_win = 0;
    endtask

    task automatic model_step(input logic [1:0] rq, input logic [3:0] rn);
        int d;
        int dmg;
        if (t == 0) begin
            if (!m_go && rq != 2'b00) begin
                m_att = (rq == 2'b11) ? m_ptr : rq[1];
                m_ptr = !m_att;
                t = 1;
            end
        end else if (t == S + 1) begin
            d   = m_att ? 0 : 1;
            dmg = (rn == 15) ? 2 : ((rn > 7) ? 1 : 0);
            m_hp[d] = (m_hp[d] > dmg) ? m_hp[d] - dmg : 0;
            m_lh = (rn > 7);
            m_la = m_att;
            if (m_hp[d] == 0) begin
                m_go  = 1;
                m_win = m_att;
            end
            t = t + 1;
        end else if (t == S + 2) begin
            t = 0;
        end else begin
            t = t + 1;
        end
    endtask

    task automatic check_all();
        logic [1:0] exp_ack;
        exp_ack = (t == S + 2) ? (m_att ? 2'b10 : 2'b01) : 2'b00;
        chk("ack", {2'b00, ack}, {2'b00, exp_ack});
        chk("busy", {3'b000, busy}, {3'b000, (t != 0)});
        chk("hp0", hp0, m_hp[0][3:0]);
        chk("hp1", hp1, m_hp[1][3:0]);
        chk("last_hit", {3'b000, last_hit}, {3'b000, m_lh});
        chk("last_attacker", {3'b000, last_attacker}, {3'b000, m_la});
        chk("game_over", {3'b000, game_over}, {3'b000, m_go});
        if (m_go)
            chk("winner", {3'b000, winner}, {3'b000, m_win});
        if (t <= S)
            chk("rng_run", {3'b000, rng_run}, 4'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset)
            model_reset();
        else
            model_step(req, rnd);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic turn(input logic [1:0] rq, input logic [3:0] rn, input bit hold);
        req = rq;
        rnd = rn;
        tick();
        if (!hold)
            req = 2'b00;
        repeat (S + 1) tick();
        chk("turn_ack_latency", {2'b00, ack}, {2'b00, rq});
        req = 2'b00;
        tick();
    endtask

    logic [1:0] rr_id[8];
    int         rr_cyc[8];
    int         rr_n;

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        rnd   = 4'h0;
        model_reset();
        do_reset();

        // Player 0 hits with 9
        turn(2'b01, 4'h9, 1'b1);
        chk("tp1_hp1", hp1, 4'd8);
        chk("tp1_hp0", hp0, 4'd9);
        chk("tp1_last_hit", {3'b000, last_hit}, 4'd1);
        chk("tp1_last_att", {3'b000, last_attacker}, 4'd0);

        // Player 1 misses, then hits for 2
        turn(2'b10, 4'h3, 1'b1);
        chk("tp2_hp0_miss", hp0, 4'd9);
        chk("tp2_last_hit", {3'b000, last_hit}, 4'd0);
        turn(2'b10, 4'hF, 1'b1);
        chk("tp2_hp0_dmg2", hp0, 4'd7);

        // Both requesting from reset: round-robin 0,1,0,1 spaced S+3
        req = 2'b11;
        do_reset();
        rr_n = 0;
        for (int i = 0; i < 24; i++) begin
            rnd = 4'($urandom_range(0, 15));
            tick();
            if (ack != 2'b00 && rr_n < 8) begin
                rr_id[rr_n]  = ack;
                rr_cyc[rr_n] = i;
                rr_n++;
            end
        end
        req = 2'b00;
        chk("rr_count", 4'(rr_n), 4'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < rr_n)
                chk("rr_order", {2'b00, rr_id[k]}, (k % 2 == 0) ? 4'd1 : 4'd2);
            if (k > 0 && k < rr_n)
                chk("rr_spacing", 4'(rr_cyc[k] - rr_cyc[k-1]), 4'(S + 3));
        end

        // Drive player 1 down to 1 HP, then a 2-damage hit must saturate at 0
        do_reset();
        repeat (4) turn(2'b01, 4'hF, 1'b1);
        chk("go_hp1_one", hp1, 4'd1);
        turn(2'b01, 4'hF, 1'b1);
        chk("go_hp1_zero", hp1, 4'd0);
        chk("go_flag", {3'b000, game_over}, 4'd1);
        chk("go_winner", {3'b000, winner}, 4'd0);
        req = 2'b11;
        repeat (20) begin
            rnd = 4'($urandom_range(0, 15));
            tick();
        end
        req = 2'b00;
        chk("go_frozen_hp0", hp0, 4'd9);
        chk("go_frozen_hp1", hp1, 4'd0);

        // Reset in the middle of a player-0 turn
        do_reset();
        req = 2'b01;
        rnd = 4'h9;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("mid_busy_cleared", {3'b000, busy}, 4'd0);
        tick();
        reset = 1'b0;
        req = 2'b11;
        repeat (S + 2) tick();
        chk("post_rst_ack0", {2'b00, ack}, 4'd1);
        chk("post_rst_hp1", hp1, 4'd8);
        req = 2'b00;
        tick();

        // One-cycle request pulses at the hit threshold boundary
        do_reset();
        turn(2'b01, 4'h7, 1'b0);
        chk("pulse_miss_7", {3'b000, last_hit}, 4'd0);
        chk("pulse_hp1_7", hp1, 4'd9);
        turn(2'b01, 4'h8, 1'b0);
        chk("pulse_hit_8", {3'b000, last_hit}, 4'd1);
        chk("pulse_hp1_8", hp1, 4'd8);

        // Random traffic with one reset in the middle
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i == 150)
                do_reset();
            req = 2'($urandom_range(0, 3));
            rnd = 4'($urandom_range(0, 15));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/battle_turn_ctrl.md
# battle_turn_ctrl

Turn controller for the battle datapath. Arbitrates attack requests from two players onto the shared ring-oscillator random source. It samples a random nibble per granted turn, resolves hit or miss, and applies damage to the defender's HP register. It sits between the player input logic (KEY/SW debounce) and the hex/LED display blocks, and owns both HP values and the end-of-game condition.

## Interface
Parameters:
- HP_INIT, 9: starting HP for both players (4-bit value, 1..15)
- HIT_THRESHOLD, 7: a turn is a hit when the sampled nibble is strictly greater than this value
- SETTLE_CYCLES, 3: wait cycles between grant and sampling, covering the oscillator-bank synchronizer (minimum 1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req  in  2  attack request level, bit n = player n; held until ack
- rnd  in  4  random nibble from the synchronized oscillator bank
- rng_run  out  1  oscillator enable (drives the bank's stop input; 1 = oscillate)
- ack  out  2  one-cycle completion pulse to the granted player
- busy  out  1  turn in progress (any state other than IDLE/OVER)
- hp0, hp1  out  4 each  current HP of player 0 and player 1
- last_hit  out  1  result of the most recent turn
- last_attacker  out  1  player index of the most recent turn
- game_over  out  1  a player's HP has reached 0
- winner  out  1  index of the player who delivered the final hit; valid while game_over=1

## Operation
- Reset values: hp0=hp1=HP_INIT, ack=0, busy=0, rng_run=1, last_hit=0, last_attacker=0, game_over=0, winner=0, priority pointer=0, state=IDLE, settle counter=0.
- States are IDLE, SETTLE, RESOLVE, REPORT and OVER.
- IDLE:
  - If any req bit is set, grant one player, latch it as the attacker, clear the settle counter and go to SETTLE.
  - Arbitration: a single requester always wins. When both request, the player selected by the priority pointer wins.
  - After each grant, the pointer is set to the non-granted player (round-robin).
- SETTLE: rng_run=1. The counter increments each cycle. After SETTLE_CYCLES cycles in SETTLE, go to RESOLVE.
- RESOLVE: sample rnd into an internal register.
  - hit = (sample > HIT_THRESHOLD), unsigned 4-bit compare.
  - damage = 2 if sample == 4'hF, 1 if any other hit, 0 on a miss.
  - Defender HP becomes max(HP − damage, 0). Subtraction saturates and never wraps.
  - Attacker HP is unchanged.
- REPORT:
  - ack[attacker]=1 for exactly this cycle.
  - last_hit and last_attacker are updated.
  - If defender HP is 0: set game_over=1 and winner=attacker, then go to OVER. Otherwise go to IDLE.
- OVER: absorbing state. Requests are ignored, no further ack is issued, HP is frozen, and rng_run=1. The only exit is reset.
- Dropping req mid-turn does not abort the turn; the ack still pulses in REPORT. A req held high through the ack cycle counts as a new request in the following IDLE cycle.
- Reset asserted in any state returns every output to its reset value asynchronously, including mid-turn. Any partial turn is discarded.

## Timing
- Cycle 0: IDLE with req sampled high, grant occurs; busy rises in cycle 1.
- Cycles 1..SETTLE_CYCLES: SETTLE.
- Cycle SETTLE_CYCLES+1: RESOLVE; rnd is sampled on this cycle's clock edge.
- Cycle SETTLE_CYCLES+2: REPORT. ack is high, and the updated hp0/hp1, last_hit and game_over are all visible in this cycle.
- Cycle SETTLE_CYCLES+3: IDLE (busy=0) or OVER.
- Request-to-ack latency is SETTLE_CYCLES+2 cycles; the minimum turn-to-turn spacing is SETTLE_CYCLES+3 cycles.
- All outputs are registered with no combinational path from req or rnd. ack is decoded from state and attacker only.

## Test plan
- Reset, then req=2'b01 with rnd=4'h9 held: ack=2'b01 in cycle 5, hp1 9→8, hp0=9, last_hit=1, last_attacker=0.
- req=2'b10 with rnd=4'h3: ack=2'b10 at latency 5, hp0 unchanged at 9, last_hit=0. Then rnd=4'hF: hp0 9→7 (damage 2).
- req=2'b11 held continuously from reset: grants alternate player 0, 1, 0, 1. Each ack is one cycle wide, and turns are spaced 6 cycles apart.
- Defender at hp=1, attacker hits with rnd=4'hF: hp goes to 0 (no wrap to 4'hF), game_over=1, winner=attacker. Further req produces no ack and no HP change.
- Assert reset during SETTLE of a player-0 turn: all outputs return to reset values at once, no ack is issued, hp1 stays 9, and the next grant goes to player 0.
- req pulsed for 1 cycle only: the turn still completes and ack pulses at latency 5. rnd=4'h7 produces a miss (threshold boundary); rnd=4'h8 produces a hit.
